// File: rtl/mvau_defn.sv
// ---------------------------------------------------------------------------
// mvau_defn
//   Shared definitions for the binarised MVU processing element.
//   Packages cannot take parameters, so PCW/CNTW/pc_t/acc_t describe the
//   default build (SIMD=8, MAX_FOLD=256, TDstI=16). The width helper
//   functions let parameterised modules derive the same widths for any
//   configuration.
// ---------------------------------------------------------------------------
package mvau_defn;

  localparam int SIMD_DEF     = 8;
  localparam int TDSTI_DEF    = 16;
  localparam int MAX_FOLD_DEF = 256;

  localparam int PCW  = $clog2(SIMD_DEF + 1);
  localparam int CNTW = $clog2(MAX_FOLD_DEF + 1);

  typedef logic [PCW-1:0]       pc_t;
  typedef logic [TDSTI_DEF-1:0] acc_t;

  // Bits needed to hold a popcount of 0..simd.
  function automatic int pc_width(input int simd);
    return $clog2(simd + 1);
  endfunction

  // Bits needed to hold a beat count of 0..max_fold.
  function automatic int cnt_width(input int max_fold);
    return $clog2(max_fold + 1);
  endfunction

endpackage

// File: rtl/mvu_popcount.sv
// ---------------------------------------------------------------------------
// mvu_popcount
//   Combinational adder-tree popcount over SIMD bits. Leaves are padded to
//   the next power of two with zeros; the tree is stored heap-style
//   (node k has children 2k+1 and 2k+2, root is node 0).
// Ports:
//   bits  in  SIMD  bits to count
//   cnt   out PCW   number of ones in bits
// ---------------------------------------------------------------------------
module mvu_popcount
  import mvau_defn::*;
#(
  parameter int SIMD = 8,
  parameter int PCW  = pc_width(SIMD)
) (
  input  logic [SIMD-1:0] bits,
  output logic [PCW-1:0]  cnt
);

  localparam int N = 1 << $clog2(SIMD);

  always_comb begin : tree
    logic [PCW-1:0] node [2*N-1];
    // NOTE: every node is assigned on every evaluation, so no latch is inferred.
    for (int i = 0; i < SIMD; i++) node[N-1+i] = PCW'(bits[i]);
    for (int i = SIMD; i < N; i++) node[N-1+i] = '0;
    for (int k = N - 2; k >= 0; k--) node[k] = node[2*k+1] + node[2*k+2];
    cnt = node[0];
  end

endmodule

// File: rtl/mvu_pe_simd_xnor_acc.sv
// ---------------------------------------------------------------------------
// mvu_pe_simd_xnor_acc
//   Binarised MVU processing element. Each accepted beat XNORs a SIMD-wide
//   activation vector with a weight vector and popcounts the matches (S1);
//   S2 accumulates popcounts across the fold beats of a row and emits one
//   dot product per row. A single advance signal stalls the whole pipe when
//   a result is held by downstream back-pressure.
//
//   Optional build macro BIPOLAR_OUT_EN: when defined, out is the signed
//   +1/-1 dot product 2*matches - SIMD*beats (two's complement, TDstI bits);
//   when undefined, out is the unsigned match count.
//
// Ports:
//   clk      in   1      clock
//   rst_n    in   1      asynchronous active-low reset
//   in_v     in   1      input beat valid
//   in_rdy   out  1      input beat ready (= pipeline advance)
//   in_act   in   SIMD   activation bits, lane i = bit i
//   in_wgt   in   SIMD   weight bits, lane i = bit i
//   in_last  in   1      final beat of the current row
//   out_v    out  1      result valid
//   out_rdy  in   1      result accepted downstream
//   out      out  TDstI  dot-product result
// ---------------------------------------------------------------------------
module mvu_pe_simd_xnor_acc
  import mvau_defn::*;
#(
  parameter int SIMD     = 8,
  parameter int TDstI    = 16,
  parameter int MAX_FOLD = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_v,
  output logic             in_rdy,
  input  logic [SIMD-1:0]  in_act,
  input  logic [SIMD-1:0]  in_wgt,
  input  logic             in_last,
  output logic             out_v,
  input  logic             out_rdy,
  output logic [TDstI-1:0] out
);

  localparam int PC_W  = pc_width(SIMD);
  localparam int CNT_W = cnt_width(MAX_FOLD);

  // Whole pipe moves together; it only stops when a held result blocks S2.
  logic adv;
  assign adv    = !out_v || out_rdy;
  assign in_rdy = adv;

  // ---------------- S1: XNOR + popcount ----------------
  logic [SIMD-1:0] match;
  logic [PC_W-1:0] pc_comb;

  assign match = in_act ~^ in_wgt;

  mvu_popcount #(
    .SIMD (SIMD),
    .PCW  (PC_W)
  ) u_popcount (
    .bits (match),
    .cnt  (pc_comb)
  );

  logic            s1_v;
  logic            s1_last;
  logic [PC_W-1:0] s1_pc;

  // ---------------- S2: accumulate ----------------
  logic [TDstI-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [TDstI-1:0] sum;
  logic [TDstI-1:0] result;

  assign sum = acc + TDstI'(s1_pc);

`ifdef BIPOLAR_OUT_EN
  // Beats in this row including the current (last) one.
  logic [TDstI-1:0] beats;
  assign beats  = TDstI'(cnt) + TDstI'(1);
  assign result = (sum << 1) - TDstI'(SIMD) * beats;
`else
  assign result = sum;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_pc   <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_v   <= 1'b0;
      out     <= '0;
    end else if (adv) begin
      s1_v <= in_v;
      // Data is only captured on acceptance; it is don't-care otherwise.
      if (in_v) begin
        s1_pc   <= pc_comb;
        s1_last <= in_last;
      end

      // A held result was consumed (or there was none); raise out_v only
      // when a row completes this cycle, otherwise out keeps its value.
      out_v <= s1_v && s1_last;
      if (s1_v) begin
        if (s1_last) begin
          out <= result;
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  // A non-last beat arriving with MAX_FOLD-1 beats already counted would
  // take the row past MAX_FOLD beats without in_last.
  a_fold_overrun : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(adv && s1_v && !s1_last && (cnt == CNT_W'(MAX_FOLD - 1)))
  ) else $error("mvu_pe_simd_xnor_acc: row exceeded MAX_FOLD beats");
`endif

endmodule

// File: tb/tb_mvu_pe_simd_xnor_acc.sv
// ---------------------------------------------------------------------------
// tb_mvu_pe_simd_xnor_acc
//   Directed bench. Instance u_dut8 is the default configuration (SIMD=8);
//   instance u_dut64 (SIMD=64, TDstI=16, MAX_FOLD=256) covers the full-fold
//   no-wrap case. Inputs are driven and outputs sampled 1 time unit after
//   the rising edge. Expected values are hand-computed match counts,
//   converted to the bipolar form when BIPOLAR_OUT_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mvu_pe_simd_xnor_acc;

  logic        clk;
  logic        rst_n;

  logic        in_v, in_rdy, in_last, out_v, out_rdy;
  logic [7:0]  in_act, in_wgt;
  logic [15:0] out;

  logic        in_v_b, in_rdy_b, in_last_b, out_v_b, out_rdy_b;
  logic [63:0] in_act_b, in_wgt_b;
  logic [15:0] out_b;

  int n_vec  = 0;
  int n_fail = 0;

  mvu_pe_simd_xnor_acc #(
    .SIMD (8), .TDstI (16), .MAX_FOLD (256)
  ) u_dut8 (
    .clk (clk), .rst_n (rst_n),
    .in_v (in_v), .in_rdy (in_rdy), .in_act (in_act), .in_wgt (in_wgt),
    .in_last (in_last), .out_v (out_v), .out_rdy (out_rdy), .out (out)
  );

  mvu_pe_simd_xnor_acc #(
    .SIMD (64), .TDstI (16), .MAX_FOLD (256)
  ) u_dut64 (
    .clk (clk), .rst_n (rst_n),
    .in_v (in_v_b), .in_rdy (in_rdy_b), .in_act (in_act_b), .in_wgt (in_wgt_b),
    .in_last (in_last_b), .out_v (out_v_b), .out_rdy (out_rdy_b), .out (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  // Expected output for a row with m matching lanes over the given beats.
  function automatic logic [31:0] expv(input int m, input int beats,
                                       input int simd);
`ifdef BIPOLAR_OUT_EN
    return 32'(16'(2*m - simd*beats));
`else
    return 32'(16'(m));
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat to the SIMD=8 instance for one edge.
  task automatic beat(input logic [7:0] a, input logic [7:0] w,
                      input logic l);
    in_v = 1'b1; in_act = a; in_wgt = w; in_last = l;
    step();
  endtask

  task automatic idle();
    in_v = 1'b0; in_act = 8'h00; in_wgt = 8'h00; in_last = 1'b0;
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    out_rdy = 1'b1; out_rdy_b = 1'b1;
    in_v_b = 1'b0; in_act_b = '0; in_wgt_b = '0; in_last_b = 1'b0;
    idle();

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_v", 32'(out_v), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_v_64", 32'(out_v_b), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // ---- 1: three-beat row, 8+4+8 matches ----
    beat(8'hFF, 8'hFF, 1'b0);
    beat(8'h0F, 8'h00, 1'b0);
    beat(8'hAA, 8'hAA, 1'b1);
    idle();
    check("t1_not_early", 32'(out_v), 32'd0);
    step();
    check("t1_out_v", 32'(out_v), 32'd1);
    check("t1_out", 32'(out), expv(20, 3, 8));
    step();
    check("t1_out_v_drop", 32'(out_v), 32'd0);
    check("t1_out_hold", 32'(out), expv(20, 3, 8));

    // ---- 2: single-beat rows back-to-back ----
    beat(8'h00, 8'hFF, 1'b1);
    beat(8'h01, 8'h01, 1'b1);
    idle();
    check("t2_r0_v", 32'(out_v), 32'd1);
    check("t2_r0", 32'(out), expv(0, 1, 8));
    step();
    check("t2_r1_v", 32'(out_v), 32'd1);
    check("t2_r1", 32'(out), expv(8, 1, 8));
    step();
    check("t2_drop", 32'(out_v), 32'd0);
    check("t2_hold", 32'(out), expv(8, 1, 8));

    // ---- 3: back-pressure ----
    out_rdy = 1'b0;
    beat(8'hFF, 8'hFF, 1'b0);      // row A: 8
    beat(8'hF0, 8'hF0, 1'b1);      //        +8 -> 16 over 2 beats
    beat(8'h0F, 8'hFF, 1'b1);      // row B: 4 matches, accepted into S1
    check("t3_a_v", 32'(out_v), 32'd1);
    check("t3_a", 32'(out), expv(16, 2, 8));
    in_v = 1'b1; in_act = 8'h03; in_wgt = 8'h00; in_last = 1'b1; // row C: 6
    for (int i = 0; i < 3; i++) begin
      check("t3_stall_rdy", 32'(in_rdy), 32'd0);
      check("t3_stall_out", 32'(out), expv(16, 2, 8));
      check("t3_stall_v", 32'(out_v), 32'd1);
      step();
    end
    out_rdy = 1'b1;
    #1;
    check("t3_release_rdy", 32'(in_rdy), 32'd1);
    step();                         // row C accepted, row B emitted
    idle();
    check("t3_b_v", 32'(out_v), 32'd1);
    check("t3_b", 32'(out), expv(4, 1, 8));
    step();
    check("t3_c_v", 32'(out_v), 32'd1);
    check("t3_c", 32'(out), expv(6, 1, 8));
    step();
    check("t3_drop", 32'(out_v), 32'd0);

    // ---- 4: bubbles within a 4-beat all-match row ----
    for (int i = 0; i < 4; i++) begin
      beat(8'hFF, 8'hFF, (i == 3));
      idle();
      if (i < 3) step();
    end
    lat = 1;                        // the accepting edge counts as cycle 1
    while (!out_v && lat < 10) begin
      step();
      lat++;
    end
    check("t4_latency", 32'(lat), 32'd2);
    check("t4_out", 32'(out), expv(32, 4, 8));
    step();

    // ---- 5: asynchronous reset mid-row ----
    beat(8'hFF, 8'hFF, 1'b0);
    beat(8'hFF, 8'hFF, 1'b0);
    idle();
    #3 rst_n = 1'b0;               // between edges
    #1;
    check("t5_rst_v", 32'(out_v), 32'd0);
    check("t5_rst_out", 32'(out), 32'd0);
    #2 rst_n = 1'b1;
    step();
    beat(8'hFF, 8'hFF, 1'b1);
    idle();
    step();
    check("t5_v", 32'(out_v), 32'd1);
    check("t5_out", 32'(out), expv(8, 1, 8));
    step();

    // ---- 6: SIMD=64, 256 all-match beats, no wrap ----
    for (int i = 0; i < 256; i++) begin
      in_v_b = 1'b1; in_act_b = {64{1'b1}}; in_wgt_b = {64{1'b1}};
      in_last_b = (i == 255);
      step();
    end
    in_v_b = 1'b0; in_last_b = 1'b0;
    lat = 1;
    while (!out_v_b && lat < 10) begin
      step();
      lat++;
    end
    check("t6_latency", 32'(lat), 32'd2);
    check("t6_out", 32'(out_b), expv(16384, 256, 64));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mvu_pe_simd_xnor_acc.md
Name: mvu_pe_simd_xnor_acc

Overview:
- Next-generation binarised processing element for the Matrix-Vector-Multiplication Unit.
- Each beat takes a SIMD-wide 1-bit activation vector and a 1-bit weight vector, XNORs them lane-wise and popcounts the result.
- Accumulates popcounts across a variable number of fold beats and emits one dot-product result per row.
- Pipelined, with a valid/ready handshake on both sides; replaces the single-bit registered XNOR SIMD.

Parameters:
- SIMD, 8: lanes per beat, 1..64.
- TDstI, 16: output and accumulator word length; must satisfy TDstI >= $clog2(SIMD*MAX_FOLD+1)+1.
- MAX_FOLD, 256: maximum beats per row; sizes the beat counter.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_v  in  1  input beat valid.
- in_rdy  out  1  input beat ready.
- in_act  in  SIMD  activation bits, lane i = bit i.
- in_wgt  in  SIMD  weight bits, lane i = bit i.
- in_last  in  1  final beat of the current row.
- out_v  out  1  result valid.
- out_rdy  in  1  result accepted downstream.
- out  out  TDstI  dot-product result.

Behaviour:
- Reset (asynchronous on rst_n low; released synchronously to clk):
  - out_v=0, out=0, accumulator=0, beat counter=0, all stage valids=0.
  - in_rdy=1 while in reset.
- Global advance: adv = !out_v || out_rdy. Every pipeline register updates only when adv=1. in_rdy = adv.
- Beat acceptance: a beat is accepted when in_v && in_rdy.
- Stage S1, registered:
  - pc = popcount(in_act ~^ in_wgt), width $clog2(SIMD+1).
  - s1_v, s1_last captured alongside. Bubbles (s1_v=0) are allowed.
- Stage S2, accumulate:
  - On s1_v with s1_last=0: acc <= acc + pc, cnt <= cnt + 1.
  - On s1_v with s1_last=1: out <= acc + pc, out_v <= 1, acc <= 0, cnt <= 0.
- Latency: a result appears on out 2 cycles after the last beat is accepted, with no back-pressure in between.
- Output hold: out and out_v hold stable while out_v && !out_rdy. On out_v && out_rdy with no new result, out_v <= 0 and out keeps its last value.
- Back-to-back rows:
  - A new row's first beat may directly follow the previous in_last beat.
  - Results are emitted on consecutive cycles when out_rdy=1.
- Single-beat row (in_last on first beat): out = pc.
- Arithmetic: unsigned, with wrap modulo 2^TDstI. No saturation; the parameter constraint guarantees no overflow.
- Beat counting: cnt reaching MAX_FOLD without in_last is a protocol error and is flagged by a simulation-only assertion. RTL behaviour is then unspecified.
- Reset mid-row: the partial accumulator and any pending result are discarded. No output is produced for that row.
- Input stability: in_act, in_wgt and in_last are sampled only on acceptance. They are don't-care otherwise.

Optional Feature:
- Macro BIPOLAR_OUT_EN.
- Defined: out is the signed bipolar (+1/-1) dot product, out = 2*(acc+pc) - SIMD*(cnt+1), two's complement TDstI.
  - The subtraction is computed in S2 in the same cycle, so latency is unchanged.
  - Example: SIMD=8, one beat, all lanes match -> +8; all mismatch -> -8.
- Undefined: out is the unsigned match count as described above. The bipolar logic and its multiplier-by-constant are absent.

Decomposition:
- mvau_defn.sv package holds:
  - localparam PCW = $clog2(SIMD+1).
  - localparam CNTW = $clog2(MAX_FOLD+1).
  - typedef pc_t (logic [PCW-1:0]).
  - typedef acc_t (logic [TDstI-1:0]).
- One sub-module, mvu_popcount: combinational adder-tree popcount over SIMD bits, instantiated in S1.

Test Plan:
1. SIMD=8; one row of 3 beats; act=8'hFF, wgt=8'hFF, then 8'h0F/8'h00, then 8'hAA/8'hAA; out_rdy=1 -> out=8+4+8=20 (BIPOLAR: 2*20-24=16), out_v high 2 cycles after the 3rd beat.
2. Single-beat rows back-to-back: act=8'h00, wgt=8'hFF, in_last=1; then act=8'h01, wgt=8'h01, in_last=1 -> out=0 then 8 on consecutive cycles (BIPOLAR: -8 then +8).
3. Back-pressure: hold out_rdy=0 while a result is pending and a second row streams in -> out is stable, in_rdy=0 until out_rdy=1, both results delivered in order with no loss.
4. Bubbles: in_v toggles 1/0 across a 4-beat row of all-match beats -> out=32, latency measured from the last accepted beat is 2 cycles.
5. Reset mid-row: after 2 beats, pulse rst_n low asynchronously between clock edges -> out_v=0 and out=0 immediately; the next 1-beat all-match row gives out=8 (no stale accumulation).
6. SIMD=64, MAX_FOLD=256, TDstI=16: 256 all-match beats -> out=16384, no wrap.
